// File: rtl/fifo_axis_packer.sv
// Packs RATIO FIFO words into one AXI-Stream beat, tlast every PKT_BEATS beats.
// Optional idle partial-word flush: define FLUSH_TIMEOUT_EN.
module fifo_axis_packer #(
  parameter int WIDTH        = 8,
  parameter int OUT_WIDTH    = 32,
  parameter int PKT_BEATS    = 4,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       fifo_rd_data,
  input  logic                   fifo_out_valid,
  output logic                   fifo_rd_en,
  output logic [OUT_WIDTH-1:0]   m_axis_tdata,
  output logic [OUT_WIDTH/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast
);

  localparam int RATIO  = OUT_WIDTH / WIDTH;
  localparam int LANE_W = $clog2(RATIO);
  localparam int BEAT_W = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam int KEEP_W = OUT_WIDTH / 8;
  localparam int KPL    = WIDTH / 8;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_BEATS - 1);

  if (RATIO < 2 || PKT_BEATS < 1 || IDLE_TIMEOUT < 1 ||
      (WIDTH % 8) != 0 || (OUT_WIDTH % WIDTH) != 0) begin : g_bad_cfg
    $error("fifo_axis_packer: illegal parameter set");
  end

  logic [LANE_W-1:0]    lane_cnt_q, lane_cnt_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_W-1:0]    tkeep_q, tkeep_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;

  logic xfer;
  logic can_pop;
  logic pop;

`ifdef FLUSH_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              flush_go;

  assign flush_go = (lane_cnt_q != '0) && (idle_cnt_q == IDLE_MAX) &&
                    (!tvalid_q || m_axis_tready);
  assign can_pop  = ((lane_cnt_q < LAST_LANE) || !tvalid_q || m_axis_tready) &&
                    !flush_go;
`else
  assign can_pop  = (lane_cnt_q < LAST_LANE) || !tvalid_q || m_axis_tready;
`endif

  assign xfer       = tvalid_q && m_axis_tready;
  assign pop        = fifo_out_valid && can_pop && rst_n;
  assign fifo_rd_en = pop;

  always_comb begin
    lane_cnt_d = lane_cnt_q;
    beat_cnt_d = beat_cnt_q;
    acc_d      = acc_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
`ifdef FLUSH_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
`endif

    if (xfer) begin
      tvalid_d   = 1'b0;
      beat_cnt_d = tlast_q ? '0 : beat_cnt_q + BEAT_W'(1);
    end

    if (pop) begin
      if (lane_cnt_q == LAST_LANE) begin
        tdata_d = acc_q;
        tdata_d[OUT_WIDTH-1 -: WIDTH] = fifo_rd_data;
        tkeep_d    = '1;
        tvalid_d   = 1'b1;
        // beat_cnt_d already reflects a same-edge transfer
        tlast_d    = (beat_cnt_d == LAST_BEAT);
        lane_cnt_d = '0;
      end else begin
        for (int l = 0; l < RATIO; l++) begin
          if (LANE_W'(l) == lane_cnt_q) begin
            acc_d[l*WIDTH +: WIDTH] = fifo_rd_data;
          end
        end
        lane_cnt_d = lane_cnt_q + LANE_W'(1);
      end
    end

`ifdef FLUSH_TIMEOUT_EN
    if (pop || lane_cnt_q == '0) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end

    if (flush_go) begin
      tdata_d = '0;
      tkeep_d = '0;
      for (int l = 0; l < RATIO; l++) begin
        if (LANE_W'(l) < lane_cnt_q) begin
          tdata_d[l*WIDTH +: WIDTH] = acc_q[l*WIDTH +: WIDTH];
          tkeep_d[l*KPL +: KPL]     = '1;
        end
      end
      tvalid_d   = 1'b1;
      tlast_d    = 1'b1;
      beat_cnt_d = '0;
      lane_cnt_d = '0;
      idle_cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_cnt_q <= '0;
      beat_cnt_q <= '0;
      acc_q      <= '0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
`ifdef FLUSH_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      lane_cnt_q <= lane_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      acc_q      <= acc_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
`ifdef FLUSH_TIMEOUT_EN
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_fifo_axis_packer.sv
// Randomized bench for fifo_axis_packer: source queue plus byte-stream scoreboard.
// Beats are grouped from the sourced bytes, four per beat, tlast every fourth.
module tb_fifo_axis_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  fifo_rd_data = '0;
  logic        fifo_out_valid = 1'b0;
  logic        fifo_rd_en;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;

  fifo_axis_packer #(
    .WIDTH(8), .OUT_WIDTH(32), .PKT_BEATS(4), .IDLE_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fifo_rd_data(fifo_rd_data),
    .fifo_out_valid(fifo_out_valid),
    .fifo_rd_en(fifo_rd_en),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  src[$];
  logic [7:0]  expb[$];
  logic [31:0] cap_d[$];
  logic [3:0]  cap_k[$];
  logic        cap_l[$];
  int          cap_c[$];
  int          pop_c[$];
  int          cyc;
  int          first_v;
  logic        last_rd_en;
  logic        hold_q;
  logic [31:0] hold_d;
  logic [3:0]  hold_k;
  logic        hold_l;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] b);
    src.push_back(b);
    expb.push_back(b);
  endtask

  task automatic step(input int pv, input int pr);
    logic p;
    logic x;
    @(negedge clk);
    fifo_out_valid = (src.size() > 0) && ($urandom_range(99) < pv);
    fifo_rd_data   = (src.size() > 0) ? src[0] : 8'($urandom);
    m_axis_tready  = ($urandom_range(99) < pr);
    #1;
    if (hold_q) begin
      chk("stable_valid", m_axis_tvalid, 1'b1);
      chk("stable_data", m_axis_tdata, hold_d);
      chk("stable_keep", m_axis_tkeep, hold_k);
      chk("stable_last", m_axis_tlast, hold_l);
    end
    if (m_axis_tvalid && first_v < 0) first_v = cyc;
    p = fifo_rd_en && fifo_out_valid;
    x = m_axis_tvalid && m_axis_tready;
    last_rd_en = fifo_rd_en;
    hold_q = m_axis_tvalid && !m_axis_tready;
    hold_d = m_axis_tdata;
    hold_k = m_axis_tkeep;
    hold_l = m_axis_tlast;
    @(posedge clk);
    if (p) begin
      void'(src.pop_front());
      pop_c.push_back(cyc);
    end
    if (x) begin
      cap_d.push_back(m_axis_tdata);
      cap_k.push_back(m_axis_tkeep);
      cap_l.push_back(m_axis_tlast);
      cap_c.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic run(input int n, input int pv, input int pr);
    for (int i = 0; i < n; i++) step(pv, pr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fifo_out_valid = 1'b1;
    fifo_rd_data = 8'h55;
    m_axis_tready = 1'b1;
    #1;
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, 32'h0);
    chk("rst_tkeep", m_axis_tkeep, 4'h0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    fifo_out_valid = 1'b0;
    src.delete();
    expb.delete();
    cap_d.delete();
    cap_k.delete();
    cap_l.delete();
    cap_c.delete();
    pop_c.delete();
    hold_q = 1'b0;
    cyc = 0;
    first_v = -1;
  endtask

  task automatic check_beats(input int nexp);
    chk("beat_count", cap_d.size(), nexp);
    for (int i = 0; i < cap_d.size() && i < nexp; i++) begin
      logic [31:0] e;
      e = {expb[4*i+3], expb[4*i+2], expb[4*i+1], expb[4*i]};
      chk("beat_data", cap_d[i], e);
      chk("beat_last", cap_l[i], (i % 4) == 3);
      chk("beat_keep", cap_k[i], 4'hF);
    end
  endtask

  initial begin
    int guard;
    hold_q = 1'b0;
    cyc = 0;
    first_v = -1;

    // single beat and its latency
    do_reset();
    for (int b = 1; b <= 4; b++) load(8'(b));
    run(8, 100, 100);
    check_beats(1);
    if (pop_c.size() == 4) chk("latency", first_v, pop_c[3] + 1);
    else chk("pop_count", pop_c.size(), 4);

    // back-to-back beats, wrap of beat counter
    do_reset();
    for (int b = 1; b <= 20; b++) load(8'(b));
    run(26, 100, 100);
    check_beats(5);
    if (pop_c.size() == 20) chk("no_gap_pop", pop_c[15] - pop_c[0], 15);
    else chk("pop_count", pop_c.size(), 20);
    if (cap_c.size() >= 4) chk("no_gap_beat", cap_c[3] - cap_c[0], 12);

    // downstream stall
    do_reset();
    for (int b = 1; b <= 12; b++) load(8'(b));
    run(12, 100, 0);
    chk("stall_popped", pop_c.size(), 7);
    chk("stall_rd_en", last_rd_en, 1'b0);
    chk("stall_data", m_axis_tdata, 32'h04030201);
    run(12, 100, 100);
    check_beats(3);

    // reset mid-packet discards partial data
    do_reset();
    load(8'h11);
    load(8'h22);
    run(4, 100, 100);
    chk("pre_rst_pops", pop_c.size(), 2);
    do_reset();
    for (int b = 0; b < 4; b++) load(8'hA1 + 8'(b));
    run(8, 100, 100);
    check_beats(1);

    // partial word left idle
    do_reset();
    load(8'h05);
    load(8'h06);
    run(40, 100, 100);
`ifdef FLUSH_TIMEOUT_EN
    chk("flush_count", cap_d.size(), 1);
    if (cap_d.size() > 0) begin
      chk("flush_data", cap_d[0], 32'h00000605);
      chk("flush_keep", cap_k[0], 4'b0011);
      chk("flush_last", cap_l[0], 1'b1);
    end
`else
    chk("idle_no_beat", cap_d.size(), 0);
`endif

    // random traffic
    do_reset();
    for (int b = 0; b < 1000; b++) load(8'($urandom));
    guard = 0;
    while (cap_d.size() < 250 && guard < 20000) begin
`ifdef FLUSH_TIMEOUT_EN
      step(100, 80);
`else
      step(60, 50);
`endif
      guard++;
    end
    chk("rnd_done", guard < 20000, 1'b1);
    check_beats(250);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
